// File: rtl/rot_cmd_parser_pkg.sv
// Shared types and constants for the rotation command parser: FSM states,
// ASCII codes and direction encoding.
package rot_pkg;

  typedef enum logic [1:0] {
    S_DIR  = 2'd0,
    S_NUM  = 2'd1,
    S_OUT  = 2'd2,
    S_SKIP = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/rot_dec_accum.sv
// Combinational decimal accumulate step: acc*10 + digit, saturating at all-ones.
module rot_dec_accum #(
  parameter int DIST_W = 32
) (
  input  logic [DIST_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DIST_W-1:0] acc_o
);

  // Four guard bits hold acc*10+9 without wrapping (10*2^W + 9 < 16*2^W).
  logic [DIST_W+3:0] wide;

  always_comb begin
    wide  = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1)
          + {{DIST_W{1'b0}}, digit_i};
    acc_o = (|wide[DIST_W+3:DIST_W]) ? {DIST_W{1'b1}} : wide[DIST_W-1:0];
  end

endmodule

// File: rtl/rot_cmd_parser.sv
// Parses "L<n>\n" / "R<n>\n" rotation lines from a byte stream into commands.
// Optional error counter output enabled with define ROT_PARSER_ERRCNT_EN.
module rot_cmd_parser
  import rot_pkg::*;
#(
  parameter int DIST_W     = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              direction,
  output logic [DIST_W-1:0] distance,
  output logic [31:0]       line_count,
  output logic              err_pulse
`ifdef ROT_PARSER_ERRCNT_EN
  ,
  output logic [31:0]       err_count
`endif
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e              state_q;
  logic                dir_q;
  logic [DIST_W-1:0]   acc_q;
  logic [DIST_W-1:0]   acc_d;
  logic [CNT_W-1:0]    ndig_q;
  logic                cmd_valid_q;
  logic                err_q;
  logic [31:0]         lc_q;
  logic                byte_fire;

  assign byte_ready = (state_q != S_OUT);
  assign byte_fire  = byte_valid && byte_ready;
  assign cmd_valid  = cmd_valid_q;
  assign direction  = dir_q;
  assign distance   = acc_q;
  assign line_count = lc_q;
  assign err_pulse  = err_q;

  rot_dec_accum #(.DIST_W(DIST_W)) u_accum (
    .acc_i   (acc_q),
    .digit_i (byte_data[3:0]),
    .acc_o   (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DIR;
      dir_q       <= DIR_L;
      acc_q       <= '0;
      ndig_q      <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      lc_q        <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_DIR: if (byte_fire) begin
          if (byte_data == ASCII_L || byte_data == ASCII_R) begin
            dir_q   <= (byte_data == ASCII_R) ? DIR_R : DIR_L;
            acc_q   <= '0;
            ndig_q  <= '0;
            state_q <= S_NUM;
          end else if (byte_data != ASCII_LF && byte_data != ASCII_CR &&
                       byte_data != ASCII_SP) begin
            err_q   <= 1'b1;
            state_q <= S_SKIP;
          end
        end
        S_NUM: if (byte_fire) begin
          if (is_digit(byte_data)) begin
            if (ndig_q == CNT_W'(MAX_DIGITS)) begin
              err_q   <= 1'b1;
              state_q <= S_SKIP;
            end else begin
              acc_q  <= acc_d;
              ndig_q <= ndig_q + 1'b1;
            end
          end else if (byte_data == ASCII_LF) begin
            if (ndig_q != '0) begin
              cmd_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DIR;
            end
          end else if (byte_data != ASCII_CR) begin
            err_q   <= 1'b1;
            state_q <= S_SKIP;
          end
        end
        S_OUT: if (cmd_ready) begin
          cmd_valid_q <= 1'b0;
          lc_q        <= lc_q + 32'd1;
          state_q     <= S_DIR;
        end
        S_SKIP: if (byte_fire && byte_data == ASCII_LF) begin
          state_q <= S_DIR;
        end
        default: state_q <= S_DIR;
      endcase
    end
  end

`ifdef ROT_PARSER_ERRCNT_EN
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_q && err_cnt_q != 32'hFFFF_FFFF) begin
      err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rot_cmd_parser.sv
// Directed bench for rot_cmd_parser: streams rotation text and checks commands,
// error pulses, line counting, back-pressure and reset-in-S_OUT behaviour.
module tb_rot_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        direction;
  logic [31:0] distance;
  logic [31:0] line_count;
  logic        err_pulse;
`ifdef ROT_PARSER_ERRCNT_EN
  logic [31:0] err_count;
`endif

  rot_cmd_parser #(.DIST_W(32), .MAX_DIGITS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .direction  (direction),
    .distance   (distance),
    .line_count (line_count),
    .err_pulse  (err_pulse)
`ifdef ROT_PARSER_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_errp = 0;
  bit          q_dir[$];
  logic [31:0] q_dist[$];

  // Inputs change only at posedge+1, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        q_dir.push_back(direction);
        q_dist.push_back(distance);
      end
      if (err_pulse) n_errp++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    waits      = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!byte_ready) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    int w;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], w);
    byte_valid = 1'b0;
  endtask

  int w;
  int e0;

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    cmd_ready  = 1'b1;
    cycles(2);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_direction", direction, 0);
    check("rst_distance", distance, 0);
    check("rst_line_count", line_count, 0);
    check("rst_byte_ready", byte_ready, 1);
    rst_n = 1'b1;
    cycles(1);

    // Two back-to-back commands, cmd_ready high
    e0 = n_errp;
    q_dir.delete(); q_dist.delete();
    send_str("L68\n");
    send_byte("R", w);
    check("thru_wait", w, 1);
    send_str("30\n");
    cycles(3);
    check("t40_ncmd", q_dir.size(), 2);
    if (q_dir.size() == 2) begin
      check("t40_dir0", q_dir[0], 0);
      check("t40_dist0", q_dist[0], 68);
      check("t40_dir1", q_dir[1], 1);
      check("t40_dist1", q_dist[1], 30);
    end
    check("t40_lc", line_count, 2);
    check("t40_errs", n_errp - e0, 0);

    // Back-pressure: cmd_ready low for 4 cycles
    q_dir.delete(); q_dist.delete();
    cmd_ready = 1'b0;
    send_str("R5\n");
    check("t41_latency_valid", cmd_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check("t41_hold_valid", cmd_valid, 1);
      check("t41_hold_dist", distance, 5);
      check("t41_hold_dir", direction, 1);
      check("t41_stall_ready", byte_ready, 0);
      cycles(1);
    end
    check("t41_lc_before", line_count, 2);
    cmd_ready = 1'b1;
    cycles(1);
    check("t41_valid_drop", cmd_valid, 0);
    check("t41_ready_back", byte_ready, 1);
    check("t41_lc", line_count, 3);
    cycles(2);
    check("t41_ncmd", q_dir.size(), 1);
    if (q_dir.size() == 1) check("t41_dist", q_dist[0], 5);

    // Malformed direction line is skipped
    e0 = n_errp;
    q_dir.delete(); q_dist.delete();
    send_str("X12\nL7\n");
    cycles(3);
    check("t42_ncmd", q_dir.size(), 1);
    if (q_dir.size() == 1) begin
      check("t42_dir", q_dir[0], 0);
      check("t42_dist", q_dist[0], 7);
    end
    check("t42_lc", line_count, 4);
    check("t42_errs", n_errp - e0, 1);

    // Empty number, saturation, and too many digits
    e0 = n_errp;
    q_dir.delete(); q_dist.delete();
    send_str("R\n");
    check("t43_pulse_on", err_pulse, 1);
    cycles(1);
    check("t43_pulse_off", err_pulse, 0);
    check("t43_errs_a", n_errp - e0, 1);
    send_str("L9999999999");
    check("t43_saturated", distance, 32'hFFFF_FFFF);
    check("t43_sat_noerr", n_errp - e0, 1);
    send_str("9\n");
    cycles(3);
    check("t43_errs_b", n_errp - e0, 2);
    check("t43_ncmd", q_dir.size(), 0);
    check("t43_lc", line_count, 4);

    // Max value and ignored blank / CR / space bytes
    e0 = n_errp;
    q_dir.delete(); q_dist.delete();
    send_str("R4294967295\n");
    send_str("\x0d\n\n L1\x0d\n");
    cycles(3);
    check("t44_ncmd", q_dir.size(), 2);
    if (q_dir.size() == 2) begin
      check("t44_dir0", q_dir[0], 1);
      check("t44_dist0", q_dist[0], 32'hFFFF_FFFF);
      check("t44_dir1", q_dir[1], 0);
      check("t44_dist1", q_dist[1], 1);
    end
    check("t44_lc", line_count, 6);
    check("t44_errs", n_errp - e0, 0);

    // Reset while a command waits in S_OUT
    cmd_ready = 1'b0;
    send_str("L3\n");
    check("t45_pre_valid", cmd_valid, 1);
`ifdef ROT_PARSER_ERRCNT_EN
    check("t45_pre_errcnt", err_count, 3);
`endif
    rst_n = 1'b0;
    #1;
    check("t45_valid", cmd_valid, 0);
    check("t45_lc", line_count, 0);
    check("t45_dist", distance, 0);
    check("t45_ready", byte_ready, 1);
`ifdef ROT_PARSER_ERRCNT_EN
    check("t45_errcnt", err_count, 0);
`endif
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    q_dir.delete(); q_dist.delete();
    send_str("R2\n");
    cycles(3);
    check("t45_post_ncmd", q_dir.size(), 1);
    if (q_dir.size() == 1) check("t45_post_dist", q_dist[0], 2);
    check("t45_post_lc", line_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rot_cmd_parser.md
ROT_CMD_PARSER -- requirements
Module: rot_cmd_parser

Interface
REQ-001 SHALL have parameter DIST_W, default 32: width of the distance output.
REQ-002 SHALL have parameter MAX_DIGITS, default 10: maximum decimal digits accepted per line.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port byte_valid, input, 1: byte_data holds an ASCII character.
REQ-006 SHALL have port byte_data, input, 8: ASCII character of the rotation text stream.
REQ-007 SHALL have port byte_ready, output, 1: the parser accepts the byte this cycle.
REQ-008 SHALL have port cmd_valid, output, 1: direction and distance hold a parsed command.
REQ-009 SHALL have port cmd_ready, input, 1: the downstream dial block takes the command.
REQ-010 SHALL have port direction, output, 1: 1 = 'R', 0 = 'L'.
REQ-011 SHALL have port distance, output, DIST_W: parsed decimal distance.
REQ-012 SHALL have port line_count, output, 32: number of commands handed off.
REQ-013 SHALL have port err_pulse, output, 1: one-cycle pulse per malformed line.

Function
REQ-014 SHALL transfer a byte only when byte_valid and byte_ready are both high in the same cycle.
REQ-015 SHALL transfer a command only when cmd_valid and cmd_ready are both high in the same cycle.
REQ-016 SHALL implement the states S_DIR, S_NUM, S_OUT and S_SKIP.
REQ-017 S_DIR: on 'L'/'R', latch direction, clear the accumulator and the digit count, and go to S_NUM.
REQ-018 S_DIR: on '\n', '\r' or ' ', stay in S_DIR with no error (blank lines are skipped).
REQ-019 S_DIR: on any other byte, pulse err_pulse and go to S_SKIP.
REQ-020 S_NUM: on a digit, set acc = acc*10 + digit and increment the digit count.
REQ-021 S_NUM arithmetic: if the result exceeds 2^DIST_W-1, acc SHALL saturate at all-ones with no error.
REQ-022 S_NUM: on '\r', stay in S_NUM.
REQ-023 S_NUM: on '\n' with digit count > 0, go to S_OUT.
REQ-024 S_NUM: on '\n' with digit count = 0, pulse err_pulse and go to S_DIR.
REQ-025 S_NUM: on any other byte, or on a digit that would exceed MAX_DIGITS, pulse err_pulse and go to S_SKIP.
REQ-026 S_OUT: byte_ready SHALL be 0; cmd_valid SHALL be 1; direction and distance SHALL be held stable.
REQ-027 S_OUT: on cmd_ready, go to S_DIR and increment line_count (wraps at 2^32).
REQ-028 S_SKIP: discard bytes until '\n', then go to S_DIR.
REQ-029 byte_ready SHALL be high in every state except S_OUT.
REQ-030 Latency: cmd_valid SHALL rise on the clock edge that accepts the terminating '\n'.
REQ-031 Throughput: the next line's direction byte SHALL be accepted in the cycle after the command handshake.
REQ-032 err_pulse SHALL be registered and last exactly one cycle.

Reset
REQ-033 On rst_n low, state SHALL become S_DIR immediately, regardless of the current state.
REQ-034 On rst_n low, cmd_valid, err_pulse, direction, distance and line_count SHALL be 0.
REQ-035 A command in S_OUT during reset SHALL be dropped without being counted.

Configuration
REQ-036 With ROT_PARSER_ERRCNT_EN defined, the block SHALL add output err_count, 32 bits, reset 0, incremented on every err_pulse and saturating at all-ones.
REQ-037 Without ROT_PARSER_ERRCNT_EN, the err_count port and its register SHALL be absent, with all other behaviour identical.

Structure
REQ-038 Package rot_pkg SHALL hold the state enum, the ASCII constants ('L', 'R', '0', '9', '\n', '\r', ' ') and the DIR_L/DIR_R encoding.
REQ-039 Sub-module rot_dec_accum SHALL implement the combinational saturating acc*10 + digit step.

Verification
REQ-040 Stream "L68\nR30\n" with cmd_ready held high -> two commands (dir=0, dist=68) then (dir=1, dist=30); line_count=2; err_pulse never asserted.
REQ-041 Stream "R5\n" with cmd_ready low for 4 cycles -> cmd_valid held with dist=5; byte_ready=0 throughout the stall; one handshake when cmd_ready rises.
REQ-042 Stream "X12\nL7\n" -> one err_pulse; only the command (dir=0, dist=7) is emitted; line_count=1.
REQ-043 Stream "R\n", then "L99999999999\n" with DIST_W=32 -> err_pulse on "R\n"; err_pulse on the 11th digit; no commands emitted.
REQ-044 Stream "R4294967295\n" and "\r\n\n L1\r\n" -> dist=4294967295; the blank and CR lines are ignored; then (dir=0, dist=1).
REQ-045 Assert rst_n low while in S_OUT -> cmd_valid=0 immediately and line_count=0; with ROT_PARSER_ERRCNT_EN defined, err_count=0.
